// File: rtl/cdc_pulse_tx_pkg.sv
// Shared types and constants for the cdc_pulse_tx event transmitter.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    ACK_LOW = 2'd2,
    GAP     = 2'd3
  } cdc_tx_state_t;

  localparam int unsigned MIN_HOLD_CYCLES = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_pulse_tx_chk.sv
// Simulation-only property checker bound to the cdc_pulse_tx ports.
module cdc_pulse_tx_chk #(
  parameter int unsigned CNT_W = 16
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             valid_i,
  input logic             ready_o,
  input logic             pulse_o,
  input logic [CNT_W-1:0] count_o,
  input logic             err_o
);

  a_accept_raises_pulse: assert property (@(posedge clk_i)
    (rst_ni && valid_i && ready_o) |=> pulse_o);

  a_err_sticky: assert property (@(posedge clk_i)
    (rst_ni && err_o) |=> err_o);

  a_count_step: assert property (@(posedge clk_i)
    rst_ni |=> ((count_o == $past(count_o)) ||
                (count_o == CNT_W'($past(count_o) + CNT_W'(1'b1)))));

  a_idle_is_low: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ready_o |-> !pulse_o);

endmodule

// File: rtl/cdc_pulse_tx_sync_2dff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_i domain.
module sync_2dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // first stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cdc_pulse_tx.sv
// Source-side single-bit event transmitter: timed level pulse plus mandatory low gap.
// Optional 4-phase ack handshake with timeout is enabled by defining CDC_PULSE_TX_ACK_EN.
module cdc_pulse_tx
  import cdc_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             pulse_o,
  input  logic             ack_async_i,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  localparam int unsigned TMAX = max3(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam int unsigned TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  if ((HOLD_CYCLES < MIN_HOLD_CYCLES) || (GAP_CYCLES < 1) || (ACK_TIMEOUT < 1)) begin : g_param_err
    $error("cdc_pulse_tx: HOLD_CYCLES, GAP_CYCLES and ACK_TIMEOUT must all be >= 1");
  end

  cdc_tx_state_t    state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [TW-1:0]    timer_dec_s;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;

`ifdef CDC_PULSE_TX_ACK_EN
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);

  logic ack_sync_s;
  logic ack_wait_q, ack_wait_d;
  logic err_q, err_d;

  sync_2dff #(.W(1)) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ack_async_i),
    .q_o    (ack_sync_s)
  );

  // ack_wait marks the phase of HOLD after the minimum hold has elapsed
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ack_wait_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_wait_q <= ack_wait_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic ack_unused_s;
  assign ack_unused_s = ack_async_i;
  assign err_o        = 1'b0;
`endif

  assign timer_dec_s = (timer_q == '0) ? '0 : (timer_q - TW'(1'b1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = pulse_q;
    count_d = count_q;
`ifdef CDC_PULSE_TX_ACK_EN
    ack_wait_d = ack_wait_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = HOLD;
          timer_d = HOLD_LOAD;
          pulse_d = 1'b1;
`ifdef CDC_PULSE_TX_ACK_EN
          ack_wait_d = 1'b0;
`endif
        end else begin
          pulse_d = 1'b0;
        end
      end
      HOLD: begin
`ifdef CDC_PULSE_TX_ACK_EN
        if (!ack_wait_q) begin
          if (timer_q != '0) begin
            timer_d = timer_dec_s;
          end else if (ack_sync_s) begin
            state_d = ACK_LOW;
            timer_d = ACK_LOAD;
            pulse_d = 1'b0;
          end else begin
            ack_wait_d = 1'b1;
            timer_d    = ACK_LOAD;
          end
        end else begin
          if (ack_sync_s) begin
            state_d    = ACK_LOW;
            timer_d    = ACK_LOAD;
            pulse_d    = 1'b0;
            ack_wait_d = 1'b0;
          end else if (timer_q == '0) begin
            state_d    = GAP;
            timer_d    = GAP_LOAD;
            pulse_d    = 1'b0;
            ack_wait_d = 1'b0;
            err_d      = 1'b1;
          end else begin
            timer_d = timer_dec_s;
          end
        end
`else
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
          pulse_d = 1'b0;
          count_d = count_q + CNT_W'(1'b1);
        end else begin
          timer_d = timer_dec_s;
        end
`endif
      end
      ACK_LOW: begin
        pulse_d = 1'b0;
`ifdef CDC_PULSE_TX_ACK_EN
        if (!ack_sync_s) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
          count_d = count_q + CNT_W'(1'b1);
        end else if (timer_q == '0) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_dec_s;
        end
`else
        // unreachable without the handshake; recover to a safe state
        state_d = IDLE;
        timer_d = '0;
`endif
      end
      GAP: begin
        pulse_d = 1'b0;
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_dec_s;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        pulse_d = 1'b0;
      end
    endcase
  end

  // a reset mid-event abandons it: pulse drops on this edge and nothing is counted
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign pulse_o = pulse_q;
  assign count_o = count_q;

`ifndef SYNTHESIS
  cdc_pulse_tx_chk #(.CNT_W(CNT_W)) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .pulse_o (pulse_o),
    .count_o (count_o),
    .err_o   (err_o)
  );
`endif

endmodule

// File: tb/tb_cdc_pulse_tx.sv
// Directed self-checking bench for cdc_pulse_tx (default parameters plus a CNT_W=4 instance).
module tb_cdc_pulse_tx;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ack_async_i = 1'b0;
  logic        ready_o, pulse_o, err_o;
  logic [15:0] count_o;
  logic        ready_w4, pulse_w4, err_w4;
  logic [3:0]  count_w4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdc_pulse_tx dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .pulse_o(pulse_o), .ack_async_i(ack_async_i), .count_o(count_o), .err_o(err_o)
  );

  cdc_pulse_tx #(.CNT_W(4)) dut_w4 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_w4),
    .pulse_o(pulse_w4), .ack_async_i(ack_async_i), .count_o(count_w4), .err_o(err_w4)
  );

  // Ack model: mode 1 raises ack a few cycles after pulse_o rises and drops it after it falls.
  logic       ack_mode = 1'b0;
  logic       pulse_prev = 1'b0;
  logic       ack_target = 1'b0;
  logic [3:0] ack_dly = 4'd0;
  always @(posedge clk) begin
    pulse_prev <= pulse_o;
    if (!ack_mode) begin
      ack_async_i <= 1'b0;
      ack_dly     <= 4'd0;
    end else if (pulse_o && !pulse_prev) begin
      ack_dly    <= 4'd3;
      ack_target <= 1'b1;
    end else if (!pulse_o && pulse_prev) begin
      ack_dly    <= 4'd3;
      ack_target <= 1'b0;
    end else if (ack_dly != 4'd0) begin
      ack_dly <= ack_dly - 4'd1;
      if (ack_dly == 4'd1) ack_async_i <= ack_target;
    end
  end

  typedef struct packed {
    logic        valid;
    logic        exp_ready;
    logic        exp_pulse;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [0:19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int bound);
    int n = 0;
    while (!ready_o && n < bound) begin
      step();
      n++;
    end
    check(name, ready_o, 1);
  endtask

  task automatic do_event();
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    wait_ready("event_done", 40);
  endtask

  task automatic reset_mid_hold();
    do_reset();
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    check("rst_hold_pulse_before", pulse_o, 1);
    rst_ni = 1'b0;
    step();
    check("rst_hold_pulse", pulse_o, 0);
    check("rst_hold_ready", ready_o, 1);
    check("rst_hold_count", count_o, 0);
    rst_ni = 1'b1;
    repeat (8) step();
    check("rst_hold_count_later", count_o, 0);
    check("rst_hold_ready_later", ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // one event from IDLE, busy-time requests ignored, then a second event
    vecs[0]  = '{valid:1'b1, exp_ready:1'b0, exp_pulse:1'b1, exp_count:16'd0};
    vecs[1]  = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b1, exp_count:16'd0};
    vecs[2]  = '{valid:1'b1, exp_ready:1'b0, exp_pulse:1'b1, exp_count:16'd0};
    vecs[3]  = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b1, exp_count:16'd0};
    vecs[4]  = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b0, exp_count:16'd1};
    vecs[5]  = '{valid:1'b1, exp_ready:1'b0, exp_pulse:1'b0, exp_count:16'd1};
    vecs[6]  = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b0, exp_count:16'd1};
    vecs[7]  = '{valid:1'b1, exp_ready:1'b0, exp_pulse:1'b0, exp_count:16'd1};
    vecs[8]  = '{valid:1'b0, exp_ready:1'b1, exp_pulse:1'b0, exp_count:16'd1};
    vecs[9]  = '{valid:1'b0, exp_ready:1'b1, exp_pulse:1'b0, exp_count:16'd1};
    vecs[10] = '{valid:1'b1, exp_ready:1'b0, exp_pulse:1'b1, exp_count:16'd1};
    vecs[11] = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b1, exp_count:16'd1};
    vecs[12] = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b1, exp_count:16'd1};
    vecs[13] = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b1, exp_count:16'd1};
    vecs[14] = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b0, exp_count:16'd2};
    vecs[15] = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b0, exp_count:16'd2};
    vecs[16] = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b0, exp_count:16'd2};
    vecs[17] = '{valid:1'b0, exp_ready:1'b0, exp_pulse:1'b0, exp_count:16'd2};
    vecs[18] = '{valid:1'b0, exp_ready:1'b1, exp_pulse:1'b0, exp_count:16'd2};
    vecs[19] = '{valid:1'b0, exp_ready:1'b1, exp_pulse:1'b0, exp_count:16'd2};

    do_reset();
    check("reset_ready", ready_o, 1);
    check("reset_pulse", pulse_o, 0);
    check("reset_count", count_o, 0);
    check("reset_err", err_o, 0);
    check("reset_count_w4", count_w4, 0);

`ifndef CDC_PULSE_TX_ACK_EN
    for (int i = 0; i < 20; i++) begin
      valid_i = vecs[i].valid;
      step();
      check($sformatf("vec%0d_ready", i), ready_o, vecs[i].exp_ready);
      check($sformatf("vec%0d_pulse", i), pulse_o, vecs[i].exp_pulse);
      check($sformatf("vec%0d_count", i), count_o, vecs[i].exp_count);
      check($sformatf("vec%0d_err", i), err_o, 0);
    end

    // valid held for 100 edges: accepts every HOLD+GAP+1 = 9 edges
    begin
      int hi_len = 0;
      int lo_len = 0;
      int rises = 0;
      logic prev = 1'b0;
      do_reset();
      for (int i = 0; i < 120; i++) begin
        valid_i = (i < 100);
        step();
        if (pulse_o && !prev) begin
          if (rises > 0) check("stream_low_run", lo_len, 5);
          rises++;
          hi_len = 0;
        end
        if (!pulse_o && prev) begin
          check("stream_high_run", hi_len, 4);
          lo_len = 0;
        end
        if (pulse_o) hi_len++;
        else lo_len++;
        prev = pulse_o;
      end
      check("stream_rises", rises, 12);
      check("stream_count", count_o, 12);
      check("stream_count_w4", count_w4, 12);
      check("stream_ready", ready_o, 1);
    end

    // reset in the second HOLD cycle after one completed event
    do_reset();
    do_event();
    check("pre_rst_count", count_o, 1);
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    rst_ni = 1'b0;
    step();
    check("rst2_pulse", pulse_o, 0);
    check("rst2_ready", ready_o, 1);
    check("rst2_count", count_o, 0);
    rst_ni = 1'b1;
    reset_mid_hold();

    // 17 events: 4-bit counter wraps to 1
    do_reset();
    for (int i = 0; i < 17; i++) do_event();
    check("wrap_count_w4", count_w4, 1);
    check("wrap_count", count_o, 17);
    check("wrap_err_w4", err_w4, 0);
    check("wrap_err", err_o, 0);
`else
    // handshake completes: high for 7 cycles (min hold 4, ack seen through sync at +7)
    begin
      int hi_len = 0;
      int n = 0;
      ack_mode = 1'b1;
      do_reset();
      valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      while (pulse_o && n < 200) begin
        hi_len++;
        step();
        n++;
      end
      check("ack_high_len", hi_len, 7);
      check("ack_lowphase_ready", ready_o, 0);
      wait_ready("ack_done", 60);
      check("ack_count", count_o, 1);
      check("ack_err", err_o, 0);
      repeat (10) step();
      check("ack_no_extra_event", count_o, 1);
      check("ack_idle_pulse", pulse_o, 0);
    end

    // ack never arrives: 4 + 64 high cycles, sticky error, no count
    begin
      int hi_len = 0;
      int n = 0;
      ack_mode = 1'b0;
      do_reset();
      valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      while (pulse_o && n < 300) begin
        hi_len++;
        step();
        n++;
      end
      check("timeout_high_len", hi_len, 68);
      check("timeout_err", err_o, 1);
      check("timeout_count", count_o, 0);
      wait_ready("timeout_ready", 20);
      valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      check("timeout_next_accept", pulse_o, 1);
      check("timeout_err_sticky", err_o, 1);
    end

    reset_mid_hold();
    check("rst_clears_err", err_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
